// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch/decode/execute sequencer:
//   - 4-bit opcode values (instruction bits [7:4])
//   - ALU operation select codes
//   - FSM state encoding, also exported on the debug 'state' port
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU operation codes. ADD..XOR are contiguous so that
    // alu_op = opcode - OP_ADD for the arithmetic/logic group.
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_PASSB = 3'd5;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// ----------------------------------------------------------------------------
// instr_decoder
// Purely combinational instruction decoder. Looks only at the opcode field
// of the instruction register; the operand field is consumed elsewhere.
//
// Ports:
//   ir      in   DATA_W   instruction register contents
//   alu_op  out  ALUOP_W  ALU operation select
//   alu_en  out  1        instruction uses the ALU
//   reg_we  out  1        instruction writes the accumulator
//   imm_sel out  1        ALU B operand is the immediate field
//   is_jmp  out  1        unconditional jump
//   is_jz   out  1        jump if zero
//   is_hlt  out  1        halt
// ----------------------------------------------------------------------------
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ALUOP_W = 3
) (
    input  logic [DATA_W-1:0]  ir,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_en,
    output logic               reg_we,
    output logic               imm_sel,
    output logic               is_jmp,
    output logic               is_jz,
    output logic               is_hlt
);

    logic [3:0] opcode;
    logic       unused_operand;

    assign opcode         = ir[DATA_W-1:DATA_W-4];
    assign unused_operand = ^ir[DATA_W-5:0];

    always_comb begin
        alu_op  = '0;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        imm_sel = 1'b0;
        is_jmp  = 1'b0;
        is_jz   = 1'b0;
        is_hlt  = 1'b0;
        case (opcode)
            OP_LDI: begin
                alu_op  = ALUOP_W'(ALU_PASSB);
                alu_en  = 1'b1;
                reg_we  = 1'b1;
                imm_sel = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                alu_op  = ALUOP_W'(opcode - OP_ADD);
                alu_en  = 1'b1;
                reg_we  = 1'b1;
                imm_sel = 1'b1;
            end
            OP_JMP:  is_jmp = 1'b1;
            OP_JZ:   is_jz  = 1'b1;
            OP_HLT:  is_hlt = 1'b1;
            // OP_NOP and every unassigned opcode fall through as a NOP.
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_control_unit.sv
// ----------------------------------------------------------------------------
// fetch_control_unit
// Four-cycle fetch/decode/execute/advance sequencer sitting downstream of the
// program counter. Every instruction is FETCH -> DECODE -> EXECUTE -> ADVANCE;
// HLT parks the machine in HALT until reset.
//
// Ports:
//   clk          in   1        clock, posedge
//   rst          in   1        asynchronous active-high reset
//   run          in   1        start/continue, sampled only in FETCH
//   pc           in   ADDR_W   current program counter
//   zero_flag    in   1        ALU zero flag, sampled in EXECUTE for JZ
//   imem_addr    out  ADDR_W   ROM address (= pc)
//   imem_data    in   DATA_W   registered ROM data, valid one cycle later
//   ir           out  DATA_W   instruction register
//   alu_op       out  ALUOP_W  ALU operation, valid in EXECUTE
//   alu_en       out  1        ALU strobe (EXECUTE)
//   reg_we       out  1        accumulator write strobe (EXECUTE)
//   imm_sel      out  1        ALU B = ir[3:0], valid with alu_en
//   pc_enable    out  1        PC increment request (ADVANCE)
//   pc_load      out  1        PC load request (ADVANCE)
//   pc_load_addr out  ADDR_W   jump target, valid with pc_load
//   halted       out  1        sticky halt indicator
//   state        out  3        debug view of the FSM state
//
// Interface timing: the ROM address is presented in FETCH, the ROM returns
// the word in DECODE and it is captured into ir at the end of DECODE. The
// PC requests are single-cycle pulses in ADVANCE; the PC must apply them on
// that clock edge so the new value is present in the following FETCH.
// ----------------------------------------------------------------------------
module fetch_control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               zero_flag,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [DATA_W-1:0]  imem_data,
    output logic [DATA_W-1:0]  ir,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_en,
    output logic               reg_we,
    output logic               imm_sel,
    output logic               pc_enable,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_load_addr,
    output logic               halted,
    output logic [2:0]         state
);

    state_t state_q;
    state_t state_d;
    logic   taken_q;

    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_alu_en;
    logic               dec_reg_we;
    logic               dec_imm_sel;
    logic               dec_is_jmp;
    logic               dec_is_jz;
    logic               dec_is_hlt;

    // Decoding works from the registered ir only, so no strobe ever has a
    // combinational path back to imem_data.
    instr_decoder #(
        .DATA_W  (DATA_W),
        .ALUOP_W (ALUOP_W)
    ) u_decoder (
        .ir      (ir),
        .alu_op  (dec_alu_op),
        .alu_en  (dec_alu_en),
        .reg_we  (dec_reg_we),
        .imm_sel (dec_imm_sel),
        .is_jmp  (dec_is_jmp),
        .is_jz   (dec_is_jz),
        .is_hlt  (dec_is_hlt)
    );

    assign imem_addr = pc;
    assign state     = state_q;

    // State register. Outputs are decoded from this register, so the
    // asynchronous reset removes any active strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register and jump-taken flag. The flag is captured in
    // EXECUTE (where zero_flag is valid) and consumed in ADVANCE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir      <= '0;
            taken_q <= 1'b0;
        end else begin
            if (state_q == ST_DECODE) begin
                ir <= imem_data;
            end
            if (state_q == ST_EXECUTE) begin
                taken_q <= dec_is_jmp | (dec_is_jz & zero_flag);
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        alu_op       = '0;
        alu_en       = 1'b0;
        reg_we       = 1'b0;
        imm_sel      = 1'b0;
        pc_enable    = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        halted       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_op  = dec_alu_op;
                alu_en  = dec_alu_en;
                reg_we  = dec_reg_we;
                imm_sel = dec_imm_sel;
                state_d = dec_is_hlt ? ST_HALT : ST_ADVANCE;
            end
            ST_ADVANCE: begin
                // Exactly one of load/increment; wrap-around is the PC's job.
                if (taken_q) begin
                    pc_load      = 1'b1;
                    pc_load_addr = ir[ADDR_W-1:0];
                end else begin
                    pc_enable = 1'b1;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_control_unit.sv
module tb_fetch_control_unit;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] pc;
    logic       zero_flag;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] ir;
    logic [2:0] alu_op;
    logic       alu_en;
    logic       reg_we;
    logic       imm_sel;
    logic       pc_enable;
    logic       pc_load;
    logic [3:0] pc_load_addr;
    logic       halted;
    logic [2:0] state;

    logic [7:0]  rom [16];
    logic [27:0] exp_q [$];
    int          vectors;
    int          miscompares;

    fetch_control_unit #(
        .DATA_W  (8),
        .ADDR_W  (4),
        .ALUOP_W (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .pc           (pc),
        .zero_flag    (zero_flag),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ir           (ir),
        .alu_op       (alu_op),
        .alu_en       (alu_en),
        .reg_we       (reg_we),
        .imm_sel      (imm_sel),
        .pc_enable    (pc_enable),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .halted       (halted),
        .state        (state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- environment: program counter and registered ROM ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (pc_load) begin
            pc <= pc_load_addr;
        end else if (pc_enable) begin
            pc <= pc + 4'd1;
        end
    end

    always @(posedge clk) begin
        imem_data <= rom[imem_addr];
    end

    // ---------------- scoreboard ----------------
    function automatic logic [27:0] mk(input logic [2:0] st, input logic [7:0] irv,
                                       input logic [2:0] op, input logic en,
                                       input logic we, input logic imm,
                                       input logic pe, input logic pl,
                                       input logic [3:0] pla, input logic h,
                                       input logic [3:0] addr);
        return {st, irv, op, en, we, imm, pe, pl, pla, h, addr};
    endfunction

    task automatic check_now(input string tag);
        logic [27:0] e;
        logic [27:0] g;
        e = exp_q.pop_front();
        g = {state, ir, alu_op, alu_en, reg_we, imm_sel, pc_enable, pc_load,
             pc_load_addr, halted, imem_addr};
        vectors++;
        assert (g === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (st,ir,op,en,we,imm,pe,pl,pla,h,addr)",
                   tag, g, e);
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        check_now(tag);
    endtask

    function automatic logic [27:0] idle(input logic [7:0] irv, input logic [3:0] addr);
        return mk(3'd0, irv, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, addr);
    endfunction

    // Runs one instruction starting from a FETCH cycle and checks
    // DECODE, EXECUTE, ADVANCE and the following FETCH.
    task automatic instr(input string tag, input logic [7:0] old_ir, input logic [3:0] cur_pc,
                         input logic [7:0] new_ir, input logic [2:0] op, input logic strobes,
                         input logic jump, input logic [3:0] target, input logic keep_run);
        logic [3:0] npc;
        npc = jump ? target : cur_pc + 4'd1;
        run = 1'b1;
        exp_q.push_back(mk(3'd1, old_ir, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, cur_pc));
        exp_q.push_back(mk(3'd2, new_ir, op, strobes, strobes, strobes, 1'b0, 1'b0, 4'd0, 1'b0, cur_pc));
        exp_q.push_back(mk(3'd3, new_ir, 3'd0, 1'b0, 1'b0, 1'b0, ~jump, jump,
                           jump ? target : 4'd0, 1'b0, cur_pc));
        exp_q.push_back(idle(new_ir, npc));
        drain({tag, "_decode"});
        run = keep_run;
        drain({tag, "_execute"});
        drain({tag, "_advance"});
        drain({tag, "_fetch"});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        run         = 1'b0;
        zero_flag   = 1'b0;
        imem_data   = '0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h13;  // LDI 3
        rom[1] = 8'hA7;  // JMP 7
        rom[7] = 8'hB2;  // JZ 2 (not taken)
        rom[8] = 8'hB2;  // JZ 2 (taken)
        rom[2] = 8'h24;  // ADD 4
        rom[3] = 8'h39;  // SUB 9
        rom[4] = 8'hC5;  // undefined opcode -> NOP
        rom[5] = 8'hF0;  // HLT

        // Reset state
        exp_q.push_back(idle(8'h00, 4'd0));
        drain("reset");
        rst = 1'b0;

        instr("ldi",     8'h00, 4'd0, 8'h13, 3'd5, 1'b1, 1'b0, 4'd0, 1'b1);
        instr("jmp",     8'h13, 4'd1, 8'hA7, 3'd0, 1'b0, 1'b1, 4'd7, 1'b1);
        zero_flag = 1'b0;
        instr("jz_nt",   8'hA7, 4'd7, 8'hB2, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        zero_flag = 1'b1;
        instr("jz_t",    8'hB2, 4'd8, 8'hB2, 3'd0, 1'b0, 1'b1, 4'd2, 1'b1);
        zero_flag = 1'b0;
        instr("add",     8'hB2, 4'd2, 8'h24, 3'd0, 1'b1, 1'b0, 4'd0, 1'b1);
        instr("sub",     8'h24, 4'd3, 8'h39, 3'd1, 1'b1, 1'b0, 4'd0, 1'b1);
        instr("undef",   8'h39, 4'd4, 8'hC5, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1);

        // HLT: halted from the cycle after EXECUTE, no PC activity, run ignored
        run = 1'b1;
        exp_q.push_back(mk(3'd1, 8'hC5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5));
        exp_q.push_back(mk(3'd2, 8'hF0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5));
        drain("hlt_decode");
        drain("hlt_execute");
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(mk(3'd4, 8'hF0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5));
            drain("halt_hold");
        end

        // Reset leaves HALT
        rst = 1'b1;
        #1;
        exp_q.push_back(idle(8'h00, 4'd0));
        check_now("halt_reset");
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;

        // run low: sequencer idles in FETCH
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(idle(8'h00, 4'd0));
            drain("idle_run0");
        end

        // one-cycle run pulse executes exactly one instruction
        instr("pulse", 8'h00, 4'd0, 8'h13, 3'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(idle(8'h13, 4'd1));
            drain("pulse_hold");
        end

        // Reset asserted in the middle of an ADD's EXECUTE cycle
        rom[1] = 8'h24;
        run = 1'b1;
        exp_q.push_back(mk(3'd1, 8'h13, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1));
        exp_q.push_back(mk(3'd2, 8'h24, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1));
        drain("rst_add_decode");
        drain("rst_add_execute");
        #1;
        rst = 1'b1;
        #1;
        exp_q.push_back(idle(8'h00, 4'd0));
        check_now("rst_mid_execute");
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(idle(8'h00, 4'd0));
            drain("after_release");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
